alu_exec: RTL and testbench

Execution-side consumer of the 5-bit ALU control code produced by the ALU control decoder. Operands and a control code are taken on a `start` pulse, the selected operation is executed, and a registered result, a branch/compare flag and a one-cycle `done` are returned. Logic, add/sub and compare operations finish in one cycle. Multiply and divide run iteratively over WIDTH cycles, so the core's multi-cycle control stalls on `busy`.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_muldiv_seq.sv | 75 +++++++
 rtl/alu_exec.sv | 139 +++++++++++++
 tb/tb_alu_exec.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes and execution-unit state encoding.
// Imported by both the ALU control decoder and alu_exec.
package alu_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_MUL  = 5'd2;
  localparam logic [4:0] ALU_DIV  = 5'd3;
  localparam logic [4:0] ALU_AND  = 5'd4;
  localparam logic [4:0] ALU_OR   = 5'd5;
  localparam logic [4:0] ALU_NAND = 5'd6;
  localparam logic [4:0] ALU_NOR  = 5'd7;
  localparam logic [4:0] ALU_BEQ  = 5'd8;
  localparam logic [4:0] ALU_BNE  = 5'd9;
  localparam logic [4:0] ALU_BGT  = 5'd10;
  localparam logic [4:0] ALU_BLT  = 5'd11;
  localparam logic [4:0] ALU_SLT  = 5'd12;
  localparam logic [4:0] ALU_SLE  = 5'd13;
  localparam logic [4:0] ALU_SGE  = 5'd14;
  localparam logic [4:0] ALU_PASS = 5'd31;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative shift-add multiplier and restoring divider.
// res_o carries the final value combinationally while last_o is high.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] res_o
);

  localparam int CW = $clog2(WIDTH);

  logic             run_q;
  logic             div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] macc_d;

  // mul: acc=product, x=multiplicand, y=multiplier
  // div: acc=remainder, x=dividend/quotient, y=divisor
  always_comb begin
    trial  = {acc_q, x_q[WIDTH-1]};
    diff   = trial - {1'b0, y_q};
    ge     = trial >= {1'b0, y_q};
    rem_d  = ge ? WIDTH'(diff) : WIDTH'(trial);
    quo_d  = {x_q[WIDTH-2:0], ge};
    macc_d = acc_q + (y_q[0] ? x_q : '0);
  end

  assign last_o = run_q && (cnt_q == CW'(WIDTH - 1));
  assign res_o  = div_q ? quo_d : macc_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      div_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      div_q <= div_i;
      cnt_q <= '0;
      acc_q <= '0;
      x_q   <= a_i;
      y_q   <= b_i;
    end else if (run_q) begin
      cnt_q <= cnt_q + CW'(1);
      if (div_q) begin
        acc_q <= rem_d;
        x_q   <= quo_d;
      end else begin
        acc_q <= macc_d;
        x_q   <= x_q << 1;
        y_q   <= y_q >> 1;
      end
      if (last_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// ALU execution unit: single-cycle datapath plus sequencing
// of the iterative multiply/divide, with registered results.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag,
  output logic             div_zero
);

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             flag_q;
  logic             dz_q;

  logic             is_multi;
  logic             md_start;
  logic             md_last;
  logic [WIDTH-1:0] md_res;
  logic [WIDTH-1:0] sc_res;
  logic             sc_flag;
  logic             sc_dz;
  logic             lt_s;
  logic             gt_s;

  assign is_multi = (ctrl == ALU_MUL) ||
                    ((ctrl == ALU_DIV) && (b != '0));
  assign md_start = (state_q == IDLE) && start && is_multi;

  assign lt_s = $signed(a) < $signed(b);
  assign gt_s = $signed(a) > $signed(b);

  always_comb begin
    sc_res  = '0;
    sc_flag = 1'b0;
    sc_dz   = 1'b0;
    case (ctrl)
      ALU_ADD:  sc_res = a + b;
      ALU_SUB:  sc_res = a - b;
      // only reached here when the divisor is zero
      ALU_DIV: begin
        sc_res = '1;
        sc_dz  = 1'b1;
      end
      ALU_AND:  sc_res = a & b;
      ALU_OR:   sc_res = a | b;
      ALU_NAND: sc_res = ~(a & b);
      ALU_NOR:  sc_res = ~(a | b);
      ALU_BEQ:  sc_flag = (a == b);
      ALU_BNE:  sc_flag = (a != b);
      ALU_BGT:  sc_flag = gt_s;
      ALU_BLT:  sc_flag = lt_s;
      ALU_SLT: begin
        sc_flag = lt_s;
        sc_res  = {{(WIDTH-1){1'b0}}, lt_s};
      end
      ALU_SLE: begin
        sc_flag = !gt_s;
        sc_res  = {{(WIDTH-1){1'b0}}, !gt_s};
      end
      ALU_SGE: begin
        sc_flag = !lt_s;
        sc_res  = {{(WIDTH-1){1'b0}}, !lt_s};
      end
      ALU_PASS: sc_res = b;
      default: ;
    endcase
  end

  alu_muldiv_seq #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (md_start),
    .div_i   (ctrl == ALU_DIV),
    .a_i     (a),
    .b_i     (b),
    .last_o  (md_last),
    .res_o   (md_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flag_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_multi) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end else begin
              done_q   <= 1'b1;
              result_q <= sc_res;
              flag_q   <= sc_flag;
              dz_q     <= sc_dz;
            end
          end
        end
        RUN: begin
          if (md_last) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= md_res;
            flag_q   <= 1'b0;
            dz_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign flag     = flag_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: arithmetic reference model
// with per-cycle compare plus directed literal expectations.
module tb_alu_exec;

  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        flag;
  logic        div_zero;

  int checks = 0;
  int errors = 0;
  bit en = 1'b0;

  always #5 clk = ~clk;

  alu_exec #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ctrl     (ctrl),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .flag     (flag),
    .div_zero (div_zero)
  );

  typedef struct packed {
    logic [31:0] r;
    logic        f;
    logic        d;
    logic        multi;
  } mres_t;

  function automatic mres_t calc(input logic [4:0] c,
                                 input logic [31:0] x,
                                 input logic [31:0] y);
    mres_t m;
    m = '0;
    case (c)
      5'd0:  m.r = x + y;
      5'd1:  m.r = x - y;
      5'd2:  begin m.r = x * y; m.multi = 1'b1; end
      5'd3: begin
        if (y == 0) begin
          m.r = 32'hFFFF_FFFF;
          m.d = 1'b1;
        end else begin
          m.r = x / y;
          m.multi = 1'b1;
        end
      end
      5'd4:  m.r = x & y;
      5'd5:  m.r = x | y;
      5'd6:  m.r = ~(x & y);
      5'd7:  m.r = ~(x | y);
      5'd8:  m.f = (x == y);
      5'd9:  m.f = (x != y);
      5'd10: m.f = $signed(x) > $signed(y);
      5'd11: m.f = $signed(x) < $signed(y);
      5'd12: begin
        m.f = $signed(x) < $signed(y);
        m.r = {31'b0, m.f};
      end
      5'd13: begin
        m.f = $signed(x) <= $signed(y);
        m.r = {31'b0, m.f};
      end
      5'd14: begin
        m.f = $signed(x) >= $signed(y);
        m.r = {31'b0, m.f};
      end
      5'd31: m.r = y;
      default: ;
    endcase
    return m;
  endfunction

  mres_t       mr;
  int          rem_cyc;
  logic [31:0] p_res;
  logic [31:0] m_res;
  logic        m_flag;
  logic        m_dz;
  logic        m_busy;
  logic        m_done;

  always_comb mr = calc(ctrl, a, b);

  // model: rem_cyc = edges left until a mul/div completes
  always @(posedge clk) begin
    if (!rst_n) begin
      rem_cyc <= 0;
      p_res   <= '0;
      m_res   <= '0;
      m_flag  <= 1'b0;
      m_dz    <= 1'b0;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (rem_cyc > 0) begin
        rem_cyc <= rem_cyc - 1;
        if (rem_cyc == 1) begin
          m_done <= 1'b1;
          m_busy <= 1'b0;
          m_res  <= p_res;
          m_flag <= 1'b0;
          m_dz   <= 1'b0;
        end
      end else if (start) begin
        if (mr.multi) begin
          rem_cyc <= WIDTH;
          m_busy  <= 1'b1;
          p_res   <= mr.r;
        end else begin
          m_done <= 1'b1;
          m_res  <= mr.r;
          m_flag <= mr.f;
          m_dz   <= mr.d;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (en) begin
      chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
      chk("cyc_done", {31'b0, done}, {31'b0, m_done});
      chk("cyc_result", result, m_res);
      chk("cyc_flag", {31'b0, flag}, {31'b0, m_flag});
      chk("cyc_dz", {31'b0, div_zero}, {31'b0, m_dz});
    end
  end

  // called on the negedge just after the accepting edge
  task automatic wait_done(input bit noise, output int lat,
                           output int bc);
    lat = 1;
    bc  = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      start = noise && (lat % 5 == 2);
      ctrl  = 5'd0;
      a     = 32'd9;
      b     = 32'd9;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done after %0d cycles", lat);
    end
  endtask

  task automatic op(input string nm, input logic [4:0] c,
                    input logic [31:0] x, input logic [31:0] y,
                    input logic [31:0] er, input logic ef,
                    input logic ed, input int elat, input bit noise);
    int lat;
    int bc;
    start = 1'b1;
    ctrl  = c;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    wait_done(noise, lat, bc);
    chk({nm, "_res"}, result, er);
    chk({nm, "_flag"}, {31'b0, flag}, {31'b0, ef});
    chk({nm, "_dz"}, {31'b0, div_zero}, {31'b0, ed});
    chk({nm, "_lat"}, 32'(lat), 32'(elat));
    if (elat > 1) chk({nm, "_busycyc"}, 32'(bc), 32'(elat - 1));
  endtask

  initial begin
    bit saw;
    rst_n = 1'b0;
    start = 1'b0;
    ctrl  = '0;
    a     = '0;
    b     = '0;
    @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_flag", {31'b0, flag}, 32'h0);
    chk("rst_dz", {31'b0, div_zero}, 32'h0);
    rst_n = 1'b1;
    en    = 1'b1;
    @(negedge clk);

    // reset abandons an in-flight multiply
    start = 1'b1;
    ctrl  = 5'd2;
    a     = 32'd7;
    b     = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_busy", {31'b0, busy}, 32'h0);
    chk("mrst_done", {31'b0, done}, 32'h0);
    chk("mrst_result", result, 32'h0);
    rst_n = 1'b1;
    saw   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      saw |= done;
    end
    chk("mrst_nodone", {31'b0, saw}, 32'h0);

    op("mul", 5'd2, 32'd7, 32'd6, 32'd42, 0, 0, 33, 0);
    op("mulwrap", 5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
       32'h1, 0, 0, 33, 0);
    op("sub", 5'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 0, 0, 1, 0);
    op("add", 5'd0, 32'hFFFF_FFFF, 32'd2, 32'h1, 0, 0, 1, 0);
    op("nand", 5'd6, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
       32'h0F0F_0F0F, 0, 0, 1, 0);
    op("nor", 5'd7, 32'hF0F0_0000, 32'h0000_00FF,
       32'h0F0F_FF00, 0, 0, 1, 0);
    op("pass", 5'd31, 32'hDEAD_BEEF, 32'h1234,
       32'h1234, 0, 0, 1, 0);
    op("blt", 5'd11, 32'hFFFF_FFFF, 32'd1, 32'h0, 1, 0, 1, 0);
    op("sle", 5'd13, 32'd5, 32'd5, 32'h1, 1, 0, 1, 0);
    op("unused", 5'd20, 32'd5, 32'd5, 32'h0, 0, 0, 1, 0);
    op("bgt", 5'd10, -32'sd3, 32'd2, 32'h0, 0, 0, 1, 0);
    op("sge", 5'd14, 32'd2, -32'sd3, 32'h1, 1, 0, 1, 0);
    op("beq", 5'd8, 32'h55, 32'h55, 32'h0, 1, 0, 1, 0);
    op("div", 5'd3, 32'd100, 32'd7, 32'd14, 0, 0, 33, 1);
    // issued in the done cycle of the divide
    op("b2b_add", 5'd0, 32'd2, 32'd3, 32'd5, 0, 0, 1, 0);
    op("divbig", 5'd3, 32'h8000_0000, 32'd3,
       32'h2AAA_AAAA, 0, 0, 33, 0);
    op("divmax", 5'd3, 32'hFFFF_FFFF, 32'd1,
       32'hFFFF_FFFF, 0, 0, 33, 0);
    op("div0", 5'd3, 32'd55, 32'd0, 32'hFFFF_FFFF, 0, 1, 1, 0);
    op("clr_dz", 5'd0, 32'd1, 32'd1, 32'd2, 0, 0, 1, 0);

    repeat (3) @(negedge clk);
    chk("idle_done", {31'b0, done}, 32'h0);
    chk("hold_result", result, 32'd2);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
